bus_arbiter_split: RTL and testbench

- Registered, split-aware arbiter that shares one system bus between two initiators and one split-capable target returning deferred read data.
- Sits beside the bus interconnect (one instance per bus segment, e.g. main bus and bridge-side bus). It drives the grant lines and an owner select that the interconnect uses to steer address, data and ack muxes.
- Adds round-robin fairness, split parking/resume and a hold-timeout watchdog.

---
 rtl/bus_arb_pkg.sv | 21 ++
 rtl/arb_hold_timer.sv | 33 +++
 rtl/bus_arbiter_split.sv | 136 +++++++++++++
 tb/tb_bus_arbiter_split.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the split-aware two-initiator bus arbiter.
package bus_arb_pkg;

  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GNT_M1    = 2'd1,
    GNT_M2    = 2'd2,
    GNT_SPLIT = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_M1    = 2'd1,
    OWN_M2    = 2'd2,
    OWN_SPLIT = 2'd3
  } owner_e;

endpackage

// File: rtl/arb_hold_timer.sv
// Saturating hold counter; expired_c flags the last permitted cycle of a grant.
module arb_hold_timer
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero TIMEOUT disables the watchdog entirely.
  assign expired_c = (TIMEOUT != 0) && (count == TO_VAL);

endmodule

// File: rtl/bus_arbiter_split.sv
// Registered round-robin arbiter for two initiators plus a split-capable target,
// with split parking/resume and a hold-timeout watchdog.
module bus_arbiter_split
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       split_ack,
  input  logic       split_req,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       split_grant,
  output logic [1:0] bus_owner,
  output logic [1:0] split_owner,
  output logic       split_pending,
  output logic       timeout
);

  arb_state_e state, state_nxt;
  owner_e     last_served, last_nxt;
  logic       split_pending_nxt;
  logic [1:0] split_owner_nxt;
  logic       timeout_nxt;
  logic [1:0] bus_owner_nxt;
  logic       m1_elig, m2_elig, req_cur;
  logic       expired_c;
  logic       tmr_clr, tmr_en;

  arb_hold_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_hold_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .expired_c (expired_c)
  );

  assign tmr_clr = (state == IDLE) && (state_nxt != IDLE);
  assign tmr_en  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, round-robin and split bookkeeping.
  always_comb begin
    state_nxt         = state;
    last_nxt          = last_served;
    split_pending_nxt = split_pending;
    split_owner_nxt   = split_owner;
    timeout_nxt       = 1'b0;
    req_cur           = 1'b0;
    m1_elig = m1_req && !(split_pending && (split_owner == 2'(OWN_M1)));
    m2_elig = m2_req && !(split_pending && (split_owner == 2'(OWN_M2)));

    case (state)
      IDLE: begin
        if (split_pending && split_req) begin
          state_nxt = GNT_SPLIT;
        end else if (m1_elig && (!m2_elig || (last_served == OWN_M2))) begin
          state_nxt = GNT_M1;
          last_nxt  = OWN_M1;
        end else if (m2_elig) begin
          state_nxt = GNT_M2;
          last_nxt  = OWN_M2;
        end
      end
      GNT_M1, GNT_M2: begin
        req_cur = (state == GNT_M1) ? m1_req : m2_req;
        if (split_ack) begin
          split_pending_nxt = 1'b1;
          split_owner_nxt   = (state == GNT_M1) ? 2'(OWN_M1) : 2'(OWN_M2);
          state_nxt         = IDLE;
        end else if (!req_cur) begin
          state_nxt = IDLE;
        end else if (expired_c) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      GNT_SPLIT: begin
        if (!split_req) begin
          split_pending_nxt = 1'b0;
          split_owner_nxt   = 2'(OWN_NONE);
          state_nxt         = IDLE;
        end else if (expired_c) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      GNT_M1:    bus_owner_nxt = 2'(OWN_M1);
      GNT_M2:    bus_owner_nxt = 2'(OWN_M2);
      GNT_SPLIT: bus_owner_nxt = 2'(OWN_SPLIT);
      default:   bus_owner_nxt = 2'(OWN_NONE);
    endcase
  end

  // Registered outputs and split/round-robin state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      split_grant   <= 1'b0;
      bus_owner     <= 2'(OWN_NONE);
      split_owner   <= 2'(OWN_NONE);
      split_pending <= 1'b0;
      timeout       <= 1'b0;
      last_served   <= OWN_M2;
    end else begin
      m1_grant      <= (state_nxt == GNT_M1);
      m2_grant      <= (state_nxt == GNT_M2);
      split_grant   <= (state_nxt == GNT_SPLIT);
      bus_owner     <= bus_owner_nxt;
      split_owner   <= split_owner_nxt;
      split_pending <= split_pending_nxt;
      timeout       <= timeout_nxt;
      last_served   <= last_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Self-checking bench for bus_arbiter_split against a behavioural ownership model.
module tb_bus_arbiter_split;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m1_req = 1'b0, m2_req = 1'b0, split_ack = 1'b0, split_req = 1'b0;
  logic       m1_grant, m2_grant, split_grant, split_pending, timeout;
  logic [1:0] bus_owner, split_owner;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state: who owns the bus, how long, who was served last, parked split.
  int m_owner, m_cnt, m_last, m_sown;
  bit m_pend, m_to;

  bus_arbiter_split #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m1_req        (m1_req),
    .m2_req        (m2_req),
    .split_ack     (split_ack),
    .split_req     (split_req),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .split_grant   (split_grant),
    .bus_owner     (bus_owner),
    .split_owner   (split_owner),
    .split_pending (split_pending),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] dut_vec();
    return {m1_grant, m2_grant, split_grant, bus_owner, split_owner, split_pending, timeout};
  endfunction

  function automatic logic [8:0] mdl_vec();
    return {m_owner == 1, m_owner == 2, m_owner == 3, 2'(m_owner), 2'(m_sown), m_pend, m_to};
  endfunction

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_last = 2; m_sown = 0; m_pend = 0; m_to = 0;
  endtask

  // One clock of the arbitration rules, using the inputs seen at the edge.
  task automatic model_step();
    bit e1, e2, req;
    int pick;
    m_to = 0;
    if (m_owner == 0) begin
      if (m_pend && split_req) begin
        m_owner = 3; m_cnt = 0;
      end else begin
        e1 = m1_req && !(m_pend && m_sown == 1);
        e2 = m2_req && !(m_pend && m_sown == 2);
        pick = 0;
        if (e1 && e2) pick = (m_last == 1) ? 2 : 1;
        else if (e1) pick = 1;
        else if (e2) pick = 2;
        if (pick != 0) begin
          m_owner = pick; m_last = pick; m_cnt = 0;
        end
      end
    end else if (m_owner == 3) begin
      if (!split_req) begin
        m_pend = 0; m_sown = 0; m_owner = 0;
      end else if (TO != 0 && m_cnt == int'(TO)) begin
        m_owner = 0; m_to = 1;
      end else begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end else begin
      req = (m_owner == 1) ? m1_req : m2_req;
      if (split_ack) begin
        m_pend = 1; m_sown = m_owner; m_owner = 0;
      end else if (!req) begin
        m_owner = 0;
      end else if (TO != 0 && m_cnt == int'(TO)) begin
        m_owner = 0; m_to = 1;
      end else begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m1_req = 0; m2_req = 0; split_ack = 0; split_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_vec() !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", dut_vec(), 9'b0);
    end
  endtask

  task automatic test_single_m1();
    do_reset();
    m1_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec() || m1_grant !== 1'b1 || bus_owner !== 2'd1) begin
        n_fail++;
        $display("FAIL single_m1_grant cyc=%0d got=%b want=%b", cyc, dut_vec(), mdl_vec());
      end
    end
    m1_req = 0;
    tick();
    n_cmp++;
    if (dut_vec() !== mdl_vec() || m1_grant !== 1'b0 || bus_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL single_m1_release got=%b want=%b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_timeout_alternate();
    int pos, exp_own;
    bit exp_to;
    do_reset();
    m1_req = 1; m2_req = 1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      pos = (c - 1) % int'(TO + 2);
      exp_to = (pos == int'(TO + 1));
      exp_own = exp_to ? 0 : ((((c - 1) / int'(TO + 2)) % 2 == 0) ? 1 : 2);
      n_cmp++;
      if (int'(bus_owner) != exp_own || timeout !== exp_to || dut_vec() !== mdl_vec() ||
          (32'(m1_grant) + 32'(m2_grant) + 32'(split_grant)) > 1) begin
        n_fail++;
        $display("FAIL timeout_alternate c=%0d owner=%0d want_owner=%0d to=%b want_to=%b vec=%b want=%b",
                 c, bus_owner, exp_own, timeout, exp_to, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_split_resume();
    do_reset();
    m1_req = 1;
    tick();
    m2_req = 1; split_ack = 1;
    tick();
    split_ack = 0;
    n_cmp++;
    if (dut_vec() !== mdl_vec() || split_pending !== 1'b1 || split_owner !== 2'd1 || bus_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL split_park got=%b want=%b", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec() || m2_grant !== 1'b1 || m1_grant !== 1'b0) begin
        n_fail++;
        $display("FAIL split_m2_while_parked i=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
    m2_req = 0; split_req = 1;
    tick();
    tick();
    n_cmp++;
    if (dut_vec() !== mdl_vec() || split_grant !== 1'b1 || bus_owner !== 2'd3) begin
      n_fail++;
      $display("FAIL split_return_grant got=%b want=%b", dut_vec(), mdl_vec());
    end
    tick();
    split_req = 0;
    tick();
    n_cmp++;
    if (dut_vec() !== mdl_vec() || split_pending !== 1'b0 || split_owner !== 2'd0 || bus_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL split_complete got=%b want=%b", dut_vec(), mdl_vec());
    end
    tick();
    n_cmp++;
    if (dut_vec() !== mdl_vec() || m1_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL split_m1_unmasked got=%b want=%b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_split_no_pending();
    do_reset();
    split_req = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec() || split_grant !== 1'b0 || bus_owner !== 2'd0) begin
        n_fail++;
        $display("FAIL split_no_pending i=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
    split_req = 0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    m1_req = 1;
    tick();
    m2_req = 1; split_ack = 1;
    tick();
    split_ack = 0;
    tick();
    n_cmp++;
    if (m2_grant !== 1'b1 || split_pending !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_setup got=%b want=%b", dut_vec(), mdl_vec());
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b want=%b", dut_vec(), 9'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec() !== mdl_vec() || m1_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_first_tie got=%b want=%b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) m1_req = ~m1_req;
      if ($urandom_range(7) == 0) m2_req = ~m2_req;
      if ($urandom_range(5) == 0) split_req = ~split_req;
      split_ack = ($urandom_range(4) == 0);
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec() ||
          (32'(m1_grant) + 32'(m2_grant) + 32'(split_grant)) > 1) begin
        n_fail++;
        $display("FAIL random i=%0d got=%b want=%b", i, dut_vec(), mdl_vec());
      end
    end
    split_ack = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_m1();
    test_timeout_alternate();
    test_split_resume();
    test_split_no_pending();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
